// File: rtl/kb_pkg.sv
// Shared types and column-decode helpers for the keypad scan sequencer.
package kb_pkg;

    typedef enum logic {SCAN, HOLD} kb_state_t;

    localparam int KB_ROWS = 4;
    localparam int KB_COLS = 4;

    // Lowest-numbered low column wins when several keys share a row.
    function automatic logic [1:0] lo_zero_idx(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_low(input logic [3:0] col);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + 3'(!col[i]);
        end
        return n > 3'd1;
    endfunction

endpackage

// File: rtl/kb_scan_ctrl.sv
// Row-scan sequencer: strobes rows, locks onto a debounced press, emits one
// event per press and holds the row until a qualified release.
module kb_scan_ctrl
    import kb_pkg::*;
#(
    parameter int DB_DELAY = 16,
    parameter int DWELL    = 2**16 + 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KB_ROWS-1:0] db_row,
    input  logic [KB_COLS-1:0] db_col,
    input  logic               db_valid,
    input  logic               db_ok,
    output logic [KB_ROWS-1:0] row_scan,
    output logic [3:0]         key_code,
    output logic               key_valid,
    output logic               key_err,
    output logic               key_down
);

    // The row must stay put until the debouncer has had time to settle on it.
    if (DWELL < 2**DB_DELAY + 8) begin : g_dwell_chk
        $error("kb_scan_ctrl: DWELL must be >= 2**DB_DELAY + 8");
    end

    localparam logic [16:0]        DWELL_LAST = 17'(DWELL - 1);
    localparam logic [KB_ROWS-1:0] ROW0_SCAN  = 4'b1110;

    kb_state_t   state;
    logic [1:0]  row_idx;
    logic [16:0] dwell_cnt;
    logic        rel_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            row_scan  <= ROW0_SCAN;
            dwell_cnt <= '0;
            rel_seen  <= 1'b0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            case (state)
                SCAN: begin
                    // A press on the current row outranks the dwell wrap.
                    if (db_valid && db_row == row_scan) begin
                        state     <= HOLD;
                        key_code  <= {row_idx, lo_zero_idx(db_col)};
                        key_valid <= 1'b1;
                        key_err   <= multi_low(db_col);
                        key_down  <= 1'b1;
                        dwell_cnt <= '0;
                        rel_seen  <= 1'b0;
                    end else if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        row_idx   <= row_idx + 2'd1;
                        row_scan  <= {row_scan[KB_ROWS-2:0], row_scan[KB_ROWS-1]};
                    end else begin
                        dwell_cnt <= dwell_cnt + 17'd1;
                    end
                end
                HOLD: begin
                    dwell_cnt <= '0;
                    // Two back-to-back stable-and-released cycles end the hold.
                    if (db_ok && !db_valid) begin
                        if (rel_seen) begin
                            state    <= SCAN;
                            rel_seen <= 1'b0;
                            key_down <= 1'b0;
                            row_idx  <= row_idx + 2'd1;
                            row_scan <= {row_scan[KB_ROWS-2:0], row_scan[KB_ROWS-1]};
                        end else begin
                            rel_seen <= 1'b1;
                        end
                    end else begin
                        rel_seen <= 1'b0;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Directed self-checking bench for kb_scan_ctrl with a short dwell.
module tb_kb_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] db_row = 4'b1111;
    logic [3:0] db_col = 4'b1111;
    logic       db_valid = 1'b0;
    logic       db_ok = 1'b0;
    logic [3:0] row_scan;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_err;
    logic       key_down;

    int checks = 0;
    int errors = 0;

    kb_scan_ctrl #(.DB_DELAY(4), .DWELL(32)) dut (
        .clk(clk), .rst(rst), .db_row(db_row), .db_col(db_col),
        .db_valid(db_valid), .db_ok(db_ok), .row_scan(row_scan),
        .key_code(key_code), .key_valid(key_valid), .key_err(key_err),
        .key_down(key_down)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if (row_scan !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 ||
            key_err !== 1'b0 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL reset: row_scan=%b key_code=%b kv=%b ke=%b kd=%b, want 1110 0000 0 0 0",
                     row_scan, key_code, key_valid, key_err, key_down);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_row;
        int pulses;
        exp_row = 4'b1110;
        pulses = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 32; c++) begin
                step();
                if (key_valid !== 1'b0) pulses++;
                if (c == 30) begin
                    checks++;
                    if (row_scan !== exp_row) begin
                        errors++;
                        $display("FAIL idle_dwell_end r%0d: row_scan=%b want %b", r, row_scan, exp_row);
                    end
                end
            end
            exp_row = {exp_row[2:0], exp_row[3]};
            checks++;
            if (row_scan !== exp_row) begin
                errors++;
                $display("FAIL idle_advance r%0d: row_scan=%b want %b", r, row_scan, exp_row);
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL idle_no_event: pulses=%0d want 0", pulses);
        end
    endtask

    task automatic wait_row(input logic [3:0] target);
        int n;
        n = 0;
        while (row_scan !== target && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (row_scan !== target) begin
            errors++;
            $display("FAIL wait_row: row_scan=%b want %b (timeout)", row_scan, target);
        end
    endtask

    task automatic test_single_press_release();
        int pulses;
        wait_row(4'b1011);
        db_row = 4'b1011; db_col = 4'b1101; db_valid = 1'b1; db_ok = 1'b0;
        step();
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'b1001 || key_down !== 1'b1 ||
            key_err !== 1'b0 || row_scan !== 4'b1011) begin
            errors++;
            $display("FAIL press_r2c1: kv=%b code=%b kd=%b ke=%b row=%b, want 1 1001 1 0 1011",
                     key_valid, key_code, key_down, key_err, row_scan);
        end
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (key_valid !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0 || key_down !== 1'b1 || row_scan !== 4'b1011) begin
            errors++;
            $display("FAIL held_key: extra_pulses=%0d kd=%b row=%b, want 0 1 1011",
                     pulses, key_down, row_scan);
        end
        db_valid = 1'b0; db_ok = 1'b1;
        step();
        checks++;
        if (key_down !== 1'b1 || row_scan !== 4'b1011) begin
            errors++;
            $display("FAIL release_1st: kd=%b row=%b, want 1 1011", key_down, row_scan);
        end
        step();
        checks++;
        if (key_down !== 1'b0 || row_scan !== 4'b0111 || key_code !== 4'b1001 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_2nd: kd=%b row=%b code=%b kv=%b, want 0 0111 1001 0",
                     key_down, row_scan, key_code, key_valid);
        end
        db_ok = 1'b0;
    endtask

    task automatic test_release_bounce();
        int pulses;
        db_row = 4'b0111; db_col = 4'b1110; db_valid = 1'b1;
        step();
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'b1100) begin
            errors++;
            $display("FAIL press_r3c0: kv=%b code=%b, want 1 1100", key_valid, key_code);
        end
        pulses = 0;
        db_valid = 1'b0; db_ok = 1'b1; step();
        db_ok = 1'b0;
        for (int i = 0; i < 5; i++) step();
        db_ok = 1'b1; step();
        db_ok = 1'b0; db_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (key_valid !== 1'b0) pulses++;
        end
        checks++;
        if (key_down !== 1'b1 || pulses != 0 || row_scan !== 4'b0111) begin
            errors++;
            $display("FAIL bounce_hold: kd=%b pulses=%0d row=%b, want 1 0 0111", key_down, pulses, row_scan);
        end
        db_valid = 1'b0; db_ok = 1'b1;
        step(); step();
        checks++;
        if (key_down !== 1'b0 || row_scan !== 4'b1110) begin
            errors++;
            $display("FAIL bounce_release: kd=%b row=%b, want 0 1110", key_down, row_scan);
        end
        db_ok = 1'b0;
    endtask

    task automatic test_stale_and_multi();
        int pulses;
        pulses = 0;
        db_row = 4'b1011; db_col = 4'b1110; db_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            if (key_valid !== 1'b0 || key_down !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0 || row_scan !== 4'b1101) begin
            errors++;
            $display("FAIL stale_row: bad_cycles=%0d row=%b, want 0 1101", pulses, row_scan);
        end
        db_row = 4'b1101; db_col = 4'b1010;
        step();
        checks++;
        if (key_valid !== 1'b1 || key_err !== 1'b1 || key_code !== 4'b0100) begin
            errors++;
            $display("FAIL multi_key: kv=%b ke=%b code=%b, want 1 1 0100", key_valid, key_err, key_code);
        end
        step();
        checks++;
        if (key_valid !== 1'b0 || key_err !== 1'b0) begin
            errors++;
            $display("FAIL multi_pulse_width: kv=%b ke=%b, want 0 0", key_valid, key_err);
        end
    endtask

    task automatic test_reset_hold_terminal();
        rst = 1'b1;
        step();
        checks++;
        if (row_scan !== 4'b1110 || key_down !== 1'b0 || key_valid !== 1'b0 ||
            key_err !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset_in_hold: row=%b kd=%b kv=%b ke=%b code=%b, want 1110 0 0 0 0000",
                     row_scan, key_down, key_valid, key_err, key_code);
        end
        rst = 1'b0; db_valid = 1'b0; db_row = 4'b1111; db_col = 4'b1111;
        for (int i = 0; i < 31; i++) step();
        db_row = 4'b1110; db_col = 4'b0111; db_valid = 1'b1;
        step();
        checks++;
        if (key_valid !== 1'b1 || row_scan !== 4'b1110 || key_code !== 4'b0011 || key_down !== 1'b1) begin
            errors++;
            $display("FAIL terminal_press: kv=%b row=%b code=%b kd=%b, want 1 1110 0011 1",
                     key_valid, row_scan, key_code, key_down);
        end
        db_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_press_release();
        test_release_bounce();
        test_stale_and_multi();
        test_reset_hold_terminal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
